// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous ball centre controller: steps x then y on each accepted frame_start, bouncing at the radius limits.
// Optional feature macro: BALL_BOUNCE_CNT_EN enables the 8-bit bounce counter (otherwise bounce_cnt is tied to 0).
module ball_motion_ctrl #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int RADIUS    = 100,
    parameter int X_RESET   = 320,
    parameter int Y_RESET   = 240,
    parameter int FRAME_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic [2:0] speed,
    input  logic       pause,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       pos_valid,
    output logic       bounce_x,
    output logic       bounce_y,
    output logic [7:0] bounce_cnt
);

    typedef enum logic [1:0] {IDLE, MOVE_X, MOVE_Y, COMMIT} state_t;

    localparam logic [10:0] X_LO     = 11'(RADIUS);
    localparam logic [10:0] X_HI     = 11'(H_ACTIVE - RADIUS);
    localparam logic [10:0] Y_LO     = 11'(RADIUS);
    localparam logic [10:0] Y_HI     = 11'(V_ACTIVE - RADIUS);
    localparam logic [9:0]  X_RST    = 10'(X_RESET);
    localparam logic [9:0]  Y_RST    = 10'(Y_RESET);
    localparam logic [3:0]  DIV_LAST = 4'(FRAME_DIV - 1);

    // Returns {bounce, new_dir, new_pos[9:0]}; dir 1 means moving toward increasing coordinates.
    function automatic logic [11:0] step_axis(input logic [10:0] pos, input logic dir,
                                              input logic [2:0] s, input logic [10:0] lo,
                                              input logic [10:0] hi);
        logic [10:0] sum;
        logic [10:0] lim;
        sum = pos + 11'(s);
        lim = lo + 11'(s);
        step_axis = {1'b0, dir, pos[9:0]};
        if (s != 3'd0) begin
            if (dir) begin
                if (sum >= hi) step_axis = {1'b1, 1'b0, hi[9:0]};
                else           step_axis = {1'b0, 1'b1, sum[9:0]};
            end else begin
                if (pos <= lim) step_axis = {1'b1, 1'b1, lo[9:0]};
                else            step_axis = {1'b0, 1'b0, pos[9:0] - 10'(s)};
            end
        end
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  div_q, div_d;
    logic [9:0]  x_q, x_d, y_q, y_d;
    logic [9:0]  sx_q, sx_d, sy_q, sy_d;
    logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
    logic        ndx_q, ndx_d, ndy_q, ndy_d;
    logic        bnx_q, bnx_d, bny_q, bny_d;
    logic [2:0]  spd_q, spd_d;
    logic        pos_valid_q, pos_valid_d;
    logic        bounce_x_q, bounce_x_d, bounce_y_q, bounce_y_d;
    logic [11:0] res_x, res_y;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        case (state_q)
            IDLE: begin
                if (frame_start && !pause) begin
                    if (div_q == DIV_LAST) begin
                        state_d = MOVE_X;
                        div_d   = '0;
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end
            end
            MOVE_X:  state_d = MOVE_Y;
            MOVE_Y:  state_d = COMMIT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        res_x       = step_axis({1'b0, x_q}, dir_x_q, speed, X_LO, X_HI);
        res_y       = step_axis({1'b0, y_q}, dir_y_q, spd_q, Y_LO, Y_HI);
        x_d         = x_q;
        y_d         = y_q;
        sx_d        = sx_q;
        sy_d        = sy_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        ndx_d       = ndx_q;
        ndy_d       = ndy_q;
        bnx_d       = bnx_q;
        bny_d       = bny_q;
        spd_d       = spd_q;
        pos_valid_d = 1'b0;
        bounce_x_d  = 1'b0;
        bounce_y_d  = 1'b0;
        case (state_q)
            MOVE_X: begin
                spd_d                = speed;
                {bnx_d, ndx_d, sx_d} = res_x;
            end
            MOVE_Y: begin
                {bny_d, ndy_d, sy_d} = res_y;
            end
            COMMIT: begin
                x_d         = sx_q;
                y_d         = sy_q;
                dir_x_d     = ndx_q;
                dir_y_d     = ndy_q;
                pos_valid_d = 1'b1;
                bounce_x_d  = bnx_q;
                bounce_y_d  = bny_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= X_RST;
            y_q         <= Y_RST;
            sx_q        <= X_RST;
            sy_q        <= Y_RST;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b1;
            ndx_q       <= 1'b1;
            ndy_q       <= 1'b1;
            bnx_q       <= 1'b0;
            bny_q       <= 1'b0;
            spd_q       <= '0;
            pos_valid_q <= 1'b0;
            bounce_x_q  <= 1'b0;
            bounce_y_q  <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            ndx_q       <= ndx_d;
            ndy_q       <= ndy_d;
            bnx_q       <= bnx_d;
            bny_q       <= bny_d;
            spd_q       <= spd_d;
            pos_valid_q <= pos_valid_d;
            bounce_x_q  <= bounce_x_d;
            bounce_y_q  <= bounce_y_d;
        end
    end

`ifdef BALL_BOUNCE_CNT_EN
    logic [7:0] cnt_q, cnt_d;

    // A corner hit bounces both axes in one step but counts once.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == COMMIT && (bnx_q || bny_q)) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign bounce_cnt = cnt_q;
`else
    assign bounce_cnt = '0;
`endif

    assign ball_x    = x_q;
    assign ball_y    = y_q;
    assign pos_valid = pos_valid_q;
    assign bounce_x  = bounce_x_q;
    assign bounce_y  = bounce_y_q;

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Scoreboard bench for ball_motion_ctrl: instance A uses defaults, instance B uses FRAME_DIV=3.
module tb_ball_motion_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0;
    logic       fs_a = 1'b0, fs_b = 1'b0;
    logic [2:0] spd_a = 3'd0, spd_b = 3'd0;
    logic       pause_a = 1'b0, pause_b = 1'b0;
    logic [9:0] ball_x_a, ball_y_a, ball_x_b, ball_y_b;
    logic       pv_a, pv_b, bx_a, by_a, bx_b, by_b;
    logic [7:0] cnt_a, cnt_b;

    ball_motion_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .speed(spd_a), .pause(pause_a),
        .ball_x(ball_x_a), .ball_y(ball_y_a), .pos_valid(pv_a),
        .bounce_x(bx_a), .bounce_y(by_a), .bounce_cnt(cnt_a)
    );

    ball_motion_ctrl #(.FRAME_DIV(3)) u_b (
        .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .speed(spd_b), .pause(pause_b),
        .ball_x(ball_x_b), .ball_y(ball_y_b), .pos_valid(pv_b),
        .bounce_x(bx_b), .bounce_y(by_b), .bounce_cnt(cnt_b)
    );

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       bx;
        logic       by;
        logic [7:0] cnt;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int tests = 0;
    int fails = 0;
    int commits_a = 0;
    int commits_b = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int x, input int y, input int bx, input int by, input int c);
        exp_t e;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.bx  = 1'(bx);
        e.by  = 1'(by);
        e.cnt = 8'(c);
        return e;
    endfunction

    function automatic int ecnt(input int n);
`ifdef BALL_BOUNCE_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    always @(negedge clk) begin
        if (pv_a === 1'b1) begin
            exp_t e;
            commits_a++;
            if (q_a.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL a_unexpected_commit: got pos_valid=1, expected no commit");
            end else begin
                e = q_a.pop_front();
                check("a_ball_x", 32'(ball_x_a), 32'(e.x));
                check("a_ball_y", 32'(ball_y_a), 32'(e.y));
                check("a_bounce_x", 32'(bx_a), 32'(e.bx));
                check("a_bounce_y", 32'(by_a), 32'(e.by));
                check("a_bounce_cnt", 32'(cnt_a), 32'(e.cnt));
            end
        end
    end

    always @(negedge clk) begin
        if (pv_b === 1'b1) begin
            exp_t e;
            commits_b++;
            if (q_b.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL b_unexpected_commit: got pos_valid=1, expected no commit");
            end else begin
                e = q_b.pop_front();
                check("b_ball_x", 32'(ball_x_b), 32'(e.x));
                check("b_ball_y", 32'(ball_y_b), 32'(e.y));
                check("b_bounce_x", 32'(bx_b), 32'(e.bx));
                check("b_bounce_y", 32'(by_b), 32'(e.by));
                check("b_bounce_cnt", 32'(cnt_b), 32'(e.cnt));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    // Called at a negedge; returns at the negedge where the commit is visible.
    task automatic frame_a();
        fs_a = 1'b1;
        tick(1);
        fs_a = 1'b0;
        tick(3);
    endtask

    task automatic frame_b();
        fs_b = 1'b1;
        tick(1);
        fs_b = 1'b0;
        tick(3);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        int ex, ey;
        tick(2);
        check("rst_ball_x", 32'(ball_x_a), 32'd320);
        check("rst_ball_y", 32'(ball_y_a), 32'd240);
        check("rst_pos_valid", 32'(pv_a), 32'd0);
        check("rst_bounce_x", 32'(bx_a), 32'd0);
        check("rst_bounce_y", 32'(by_a), 32'd0);
        check("rst_bounce_cnt", 32'(cnt_a), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // Single step with latency check.
        spd_a = 3'd1;
        q_a.push_back(mk(321, 241, 0, 0, 0));
        fs_a = 1'b1;
        tick(1);
        fs_a = 1'b0;
        check("step_pv_k1", 32'(pv_a), 32'd0);
        tick(1);
        check("step_pv_k2", 32'(pv_a), 32'd0);
        tick(1);
        check("step_pv_k3", 32'(pv_a), 32'd0);
        tick(1);
        check("step_pv_k4", 32'(pv_a), 32'd1);
        tick(1);
        check("step_pv_k5", 32'(pv_a), 32'd0);

        // Edge bounce: y bounces at frame 20, x at frame 32.
        do_reset();
        spd_a = 3'd7;
        for (int n = 1; n <= 32; n++) begin
            ex = (n < 32) ? 320 + 7 * n : 540;
            ey = (n <= 20) ? 240 + 7 * n : 380 - 7 * (n - 20);
            q_a.push_back(mk(ex, ey, (n == 32) ? 1 : 0, (n == 20) ? 1 : 0,
                             ecnt(((n >= 20) ? 1 : 0) + ((n >= 32) ? 1 : 0))));
            frame_a();
        end
        tick(1);
        check("bounce_final_x", 32'(ball_x_a), 32'd540);
        check("bounce_final_y", 32'(ball_y_a), 32'd296);
        check("bounce_cnt_final", 32'(cnt_a), 32'(ecnt(2)));

        // Zero speed still commits and never bounces.
        do_reset();
        spd_a = 3'd0;
        c0 = commits_a;
        for (int n = 0; n < 4; n++) begin
            q_a.push_back(mk(320, 240, 0, 0, 0));
            frame_a();
        end
        tick(2);
        check("zero_speed_commits", 32'(commits_a - c0), 32'd4);

        // Second frame_start one cycle later is dropped.
        do_reset();
        spd_a = 3'd1;
        c0 = commits_a;
        q_a.push_back(mk(321, 241, 0, 0, 0));
        fs_a = 1'b1;
        tick(2);
        fs_a = 1'b0;
        check("drop_pv_k2", 32'(pv_a), 32'd0);
        tick(1);
        check("drop_pv_k3", 32'(pv_a), 32'd0);
        tick(1);
        check("drop_pv_k4", 32'(pv_a), 32'd1);
        tick(1);
        check("drop_pv_k5", 32'(pv_a), 32'd0);
        tick(6);
        check("drop_commits", 32'(commits_a - c0), 32'd1);

        // Reset asserted during MOVE_Y.
        do_reset();
        spd_a = 3'd3;
        q_a.push_back(mk(323, 243, 0, 0, 0));
        frame_a();
        tick(1);
        check("midrst_pre_x", 32'(ball_x_a), 32'd323);
        fs_a = 1'b1;
        tick(1);
        fs_a = 1'b0;
        tick(1);
        rst_n = 1'b0;
        #1;
        check("midrst_x", 32'(ball_x_a), 32'd320);
        check("midrst_y", 32'(ball_y_a), 32'd240);
        check("midrst_pv", 32'(pv_a), 32'd0);
        tick(1);
        rst_n = 1'b1;
        c0 = commits_a;
        tick(8);
        check("midrst_no_commit", 32'(commits_a - c0), 32'd0);
        check("midrst_hold_x", 32'(ball_x_a), 32'd320);

        // Frame divider and pause on instance B.
        do_reset();
        spd_b = 3'd2;
        c0 = commits_b;
        q_b.push_back(mk(322, 242, 0, 0, 0));
        q_b.push_back(mk(324, 244, 0, 0, 0));
        for (int n = 0; n < 6; n++) frame_b();
        tick(2);
        check("div_commits", 32'(commits_b - c0), 32'd2);
        check("div_ball_x", 32'(ball_x_b), 32'd324);
        pause_b = 1'b1;
        for (int n = 0; n < 5; n++) frame_b();
        tick(2);
        check("pause_commits", 32'(commits_b - c0), 32'd2);
        check("pause_ball_x", 32'(ball_x_b), 32'd324);
        pause_b = 1'b0;
        frame_b();
        frame_b();
        tick(2);
        check("pause_div_kept", 32'(commits_b - c0), 32'd2);
        q_b.push_back(mk(326, 246, 0, 0, 0));
        frame_b();
        tick(2);
        check("resume_commits", 32'(commits_b - c0), 32'd3);

        check("a_queue_drained", 32'(q_a.size()), 32'd0);
        check("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Frame-synchronous motion controller for the bouncing-ball VGA demo. It sits directly upstream of the pixel renderer and supplies the ball centre coordinates that the renderer compares against `pix_x`/`pix_y`. Position updates are computed only in response to a start-of-vertical-blank pulse from the sync generator, so the renderer never sees a coordinate change mid-frame. Edges bounce with clamping; speed and pause are controlled from user inputs.

## Interface

Parameters:
- `H_ACTIVE`, default 640: visible width in pixels.
- `V_ACTIVE`, default 480: visible height in pixels.
- `RADIUS`, default 100: ball radius; centre limits are [RADIUS, H_ACTIVE-RADIUS] and [RADIUS, V_ACTIVE-RADIUS].
- `X_RESET`, default 320: reset centre x. Legal only if RADIUS < X_RESET < H_ACTIVE-RADIUS.
- `Y_RESET`, default 240: reset centre y. Same legality rule against V_ACTIVE.
- `FRAME_DIV`, default 1: number of accepted frames per position step, 1..15.

Ports:
- `clk` input 1: pixel clock. This is the block's only clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `frame_start` input 1: one-cycle pulse at the first blanking line (vpos==V_ACTIVE, hpos==0).
- `speed` input 3: step size in pixels per axis, 0..7.
- `pause` input 1: level; while high, `frame_start` is ignored.
- `ball_x` output 10: committed centre x.
- `ball_y` output 10: committed centre y.
- `pos_valid` output 1: one-cycle pulse when `ball_x`/`ball_y` are committed.
- `bounce_x` output 1: one-cycle pulse, coincident with `pos_valid`, when this step bounced in x.
- `bounce_y` output 1: same as `bounce_x`, for y.
- `bounce_cnt` output 8: count of bouncing steps (see Configuration).

## Operation

- The FSM has four states: IDLE, MOVE_X, MOVE_Y, COMMIT.
  - IDLE → MOVE_X when `frame_start` && !`pause` && frame divider == FRAME_DIV-1. The divider then clears.
  - If `frame_start` && !`pause` but the divider has not reached FRAME_DIV-1, the divider increments and the FSM stays in IDLE.
  - MOVE_X → MOVE_Y → COMMIT → IDLE, unconditionally, one cycle each.
  - `frame_start` arriving outside IDLE is dropped and the divider is untouched.
- MOVE_X computes the shadow x from the committed x, in 11-bit unsigned arithmetic. Let `s` = `speed`.
  - Direction +: if x+s >= H_ACTIVE-RADIUS, then nx = H_ACTIVE-RADIUS, direction becomes −, and bounce x is flagged. Otherwise nx = x+s.
  - Direction −: if x <= RADIUS+s, then nx = RADIUS, direction becomes +, and bounce x is flagged. Otherwise nx = x−s.
  - `s`==0: nx = x, direction is unchanged, no bounce, even at a limit.
- MOVE_Y applies the same rules with V_ACTIVE.
- `speed` is sampled once, in MOVE_X, and held for MOVE_Y.
- COMMIT copies the shadow registers to `ball_x`/`ball_y`, pulses `pos_valid`, and pulses `bounce_x`/`bounce_y` per the flags. These pulses appear even when the position is unchanged (`s`==0).
- Direction registers update only at COMMIT.
- `pause` asserted while the FSM is in MOVE_X..COMMIT does not abort the step.
- Reset values: `ball_x`=X_RESET, `ball_y`=Y_RESET, both directions +, divider 0, FSM IDLE, `pos_valid`/`bounce_x`/`bounce_y`=0, `bounce_cnt`=0.
- Asserting `rst_n` low at any point, including mid-step, returns every register to its reset value immediately. No partial commit occurs.

## Timing

- `frame_start` is sampled high at edge k. The FSM is in MOVE_X after k, MOVE_Y after k+1, and COMMIT after k+2.
- Outputs are updated by edge k+3. `pos_valid` is high from edge k+3 to edge k+4.
- Latency is 3 clocks. All outputs are registered.
- Minimum `frame_start` spacing is 4 clocks. The real spacing is one frame.
- Outputs are stable for the whole active video region.

## Configuration

- `BALL_BOUNCE_CNT_EN` defined:
  - `bounce_cnt` increments by 1 at each COMMIT where `bounce_x` || `bounce_y`. A corner hit counts once.
  - The counter wraps 255→0.
- `BALL_BOUNCE_CNT_EN` undefined:
  - `bounce_cnt` is tied to 0.
  - No counter flops are built.

## Test plan

- **Reset/step.** Defaults, `speed`=1. Reset, then one `frame_start` → at k+3 `ball_x`=321, `ball_y`=241, `pos_valid` high for exactly 1 cycle, both bounce pulses 0.
- **Edge bounce.** `speed`=7, frames 1..32.
  - Frame 20: `ball_y`=380, `bounce_y`=1.
  - Frame 21: `ball_y`=373.
  - Frame 31: `ball_x`=537.
  - Frame 32: `ball_x`=540, `bounce_x`=1.
  - With the macro defined, `bounce_cnt`=2 after frame 32.
- **Pause/divider.** FRAME_DIV=3, `speed`=2.
  - 6 `frame_start` pulses with `pause`=0 → 2 commits, `ball_x`=324.
  - Then 5 pulses with `pause`=1 → no `pos_valid`, `ball_x` stays 324.
- **Zero speed.** `speed`=0, 4 frames → `pos_valid` pulses 4 times, coordinates stay 320/240, no bounce pulses.
- **Dropped pulse.** A second `frame_start` at k+1 → exactly one commit, at k+3.
- **Mid-step reset.** `rst_n` low during MOVE_Y → outputs are 320/240 immediately, with no `pos_valid` on release.
